// File: rtl/uw_window_ctrl.sv
// uw_window_ctrl: UW search sequencer that fills the sliding window, starts the correlator and thresholds its metrics.
// Optional in-hold peak tracking (uw_update port) is enabled by defining UW_PEAK_TRACK_EN.
module uw_window_ctrl #(
  parameter int WIN_LEN  = 16,
  parameter int CNT_W    = 16,
  parameter int METRIC_W = 32,
  parameter int HOLDOFF  = 64,
  parameter int OUT_MAX  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                buf_en,
  output logic                buf_clr,
  output logic                corr_start,
  input  logic [METRIC_W-1:0] metric,
  input  logic                metric_valid,
  input  logic [METRIC_W-1:0] threshold,
  output logic                uw_found,
  output logic [CNT_W-1:0]    uw_pos,
  output logic [METRIC_W-1:0] uw_metric,
  output logic [1:0]          state,
  output logic                err_spur
`ifdef UW_PEAK_TRACK_EN
  ,
  output logic                uw_update
`endif
);
  localparam int FW = $clog2(WIN_LEN + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int OW = $clog2(OUT_MAX + 1);
  typedef enum logic [1:0] {IDLE, FILL, SEARCH, HOLD} state_e;
  state_e              state_q, state_d;
  logic [FW-1:0]       fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]    metric_cnt_q, metric_cnt_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [OW-1:0]       out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]    uw_pos_q, uw_pos_d;
  logic [METRIC_W-1:0] uw_metric_q, uw_metric_d;
  logic                cs_q, cs_d, found_q, err_q, err_d;
  logic                start, full_after, detect, hold_met, peak, load, spur;
`ifdef UW_PEAK_TRACK_EN
  logic                uw_update_q;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = start ? FILL : IDLE;
    else if (!enable) state_d = IDLE;
    else if (state_q == FILL) state_d = (buf_en && fill_cnt_q == FW'(WIN_LEN - 1)) ? SEARCH : FILL;
    else if (detect) state_d = HOLD;
    else if (hold_met && hold_cnt_q == HW'(1)) state_d = SEARCH;
  end
  always_comb begin
    s_ready    = state_q != IDLE;
    buf_en     = s_valid && s_ready;
    buf_clr    = start && rst;
    corr_start = cs_q;
    uw_found   = found_q;
    uw_pos     = uw_pos_q;
    uw_metric  = uw_metric_q;
    state      = state_q;
    err_spur   = err_q;
`ifdef UW_PEAK_TRACK_EN
    uw_update  = uw_update_q;
`endif
  end
  always_comb begin
    start      = state_q == IDLE && enable && out_cnt_q == '0;
    full_after = fill_cnt_q >= FW'(WIN_LEN - 1);
    detect     = state_q == SEARCH && metric_valid && metric > threshold;
    hold_met   = state_q == HOLD && metric_valid;
`ifdef UW_PEAK_TRACK_EN
    peak       = hold_met && metric > uw_metric_q;
`else
    peak       = 1'b0;
`endif
    load         = detect || peak;
    spur         = (metric_valid && !cs_q && out_cnt_q == '0) || (cs_q && !metric_valid && out_cnt_q == OW'(OUT_MAX));
    out_cnt_d    = (cs_q == metric_valid || spur) ? out_cnt_q : cs_q ? out_cnt_q + 1'b1 : out_cnt_q - 1'b1;
    fill_cnt_d   = start ? '0 : (buf_en && fill_cnt_q != FW'(WIN_LEN)) ? fill_cnt_q + 1'b1 : fill_cnt_q;
    metric_cnt_d = start ? '0 : (metric_valid && state_q != IDLE) ? metric_cnt_q + 1'b1 : metric_cnt_q;
    hold_cnt_d   = detect ? HW'(HOLDOFF) : hold_met ? hold_cnt_q - 1'b1 : hold_cnt_q;
    // metric k belongs to the window whose newest sample has index k + WIN_LEN - 1
    uw_pos_d     = load ? metric_cnt_q + CNT_W'(WIN_LEN - 1) : uw_pos_q;
    uw_metric_d  = load ? metric : uw_metric_q;
    cs_d         = buf_en && full_after && enable;
    err_d        = err_q || spur;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fill_cnt_q   <= '0;
      metric_cnt_q <= '0;
      hold_cnt_q   <= '0;
      out_cnt_q    <= '0;
      uw_pos_q     <= '0;
      uw_metric_q  <= '0;
      cs_q         <= 1'b0;
      found_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef UW_PEAK_TRACK_EN
      uw_update_q  <= 1'b0;
`endif
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      metric_cnt_q <= metric_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      out_cnt_q    <= out_cnt_d;
      uw_pos_q     <= uw_pos_d;
      uw_metric_q  <= uw_metric_d;
      cs_q         <= cs_d;
      found_q      <= detect;
      err_q        <= err_d;
`ifdef UW_PEAK_TRACK_EN
      uw_update_q  <= peak;
`endif
    end
endmodule

// File: tb/tb_uw_window_ctrl.sv
// tb_uw_window_ctrl: directed table, hand-written corner sequences and randomized traffic
// against a behavioural model of the UW window controller (HOLDOFF reduced to 4).
module tb_uw_window_ctrl;
  localparam int WIN = 16, HO = 4, OMAX = 15;
  logic clk = 0, rst = 0, enable = 0, s_valid = 0, metric_valid = 0;
  logic [31:0] metric = 0, threshold = 0;
  logic s_ready, buf_en, buf_clr, corr_start, uw_found, err_spur;
  logic [15:0] uw_pos;
  logic [31:0] uw_metric;
  logic [1:0] state;
`ifdef UW_PEAK_TRACK_EN
  logic uw_update;
`endif
  int checks = 0, fails = 0;
  always #5 clk = ~clk;

  uw_window_ctrl #(.HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .buf_en(buf_en), .buf_clr(buf_clr), .corr_start(corr_start), .metric(metric),
    .metric_valid(metric_valid), .threshold(threshold), .uw_found(uw_found),
    .uw_pos(uw_pos), .uw_metric(uw_metric), .state(state), .err_spur(err_spur)
`ifdef UW_PEAK_TRACK_EN
    , .uw_update(uw_update)
`endif
  );

  // behavioural model: mode, samples in window, metrics seen, metrics left to ignore, requests in flight
  int m_state, m_fill, m_mcnt, m_hold, m_out;
  bit m_cs, m_found, m_upd, m_err;
  logic [15:0] m_pos;
  logic [31:0] m_met;

  typedef struct {
    bit en, sv, mv;
    logic [31:0] met;
    int st;
    bit clr, cs, fnd;
  } vec_t;
  vec_t vecs[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void add_v(bit en, bit sv, bit mv, int met, int st, bit clr, bit cs, bit fnd);
    vec_t v;
    v.en = en; v.sv = sv; v.mv = mv; v.met = met; v.st = st; v.clr = clr; v.cs = cs; v.fnd = fnd;
    vecs.push_back(v);
  endfunction

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_mcnt = 0; m_hold = 0; m_out = 0;
    m_cs = 0; m_found = 0; m_upd = 0; m_err = 0; m_pos = 0; m_met = 0;
  endtask

  task automatic check_model();
    chk("s_ready", s_ready, m_state != 0);
    chk("buf_en", buf_en, s_valid && m_state != 0);
    chk("buf_clr", buf_clr, m_state == 0 && enable && m_out == 0);
    chk("corr_start", corr_start, m_cs);
    chk("uw_found", uw_found, m_found);
    chk("uw_pos", uw_pos, m_pos);
    chk("uw_metric", uw_metric, m_met);
    chk("state", state, m_state);
    chk("err_spur", err_spur, m_err);
`ifdef UW_PEAK_TRACK_EN
    chk("uw_update", uw_update, m_upd);
`endif
  endtask

  task automatic model_next();
    bit wr, clr, hit, peak;
    int ns;
    wr   = s_valid && m_state != 0;
    clr  = m_state == 0 && enable && m_out == 0;
    hit  = m_state == 2 && metric_valid && metric > threshold;
    peak = 0;
`ifdef UW_PEAK_TRACK_EN
    peak = m_state == 3 && metric_valid && metric > m_met;
`endif
    if (m_state == 0) ns = clr ? 1 : 0;
    else if (!enable) ns = 0;
    else if (m_state == 1) ns = (wr && m_fill + 1 == WIN) ? 2 : 1;
    else if (hit) ns = 3;
    else if (m_state == 3 && metric_valid && m_hold == 1) ns = 2;
    else ns = m_state;
    if (m_cs && !metric_valid) begin
      if (m_out == OMAX) m_err = 1; else m_out++;
    end else if (metric_valid && !m_cs) begin
      if (m_out == 0) m_err = 1; else m_out--;
    end
    if (m_state == 3 && metric_valid) m_hold--;
    if (hit) m_hold = HO;
    m_found = hit;
    m_upd = peak;
    if (hit || peak) begin
      m_pos = 16'((m_mcnt + WIN - 1) % 65536);
      m_met = metric;
    end
    if (clr) begin
      m_fill = 0;
      m_mcnt = 0;
    end else begin
      if (wr && m_fill < WIN) m_fill++;
      if (m_state != 0 && metric_valid) m_mcnt = (m_mcnt + 1) % 65536;
    end
    m_cs = wr && enable && m_fill >= WIN;
    m_state = ns;
  endtask

  task automatic step(bit en, bit sv, bit mv, logic [31:0] met, logic [31:0] thr);
    enable = en; s_valid = sv; metric_valid = mv; metric = met; threshold = thr;
    #1;
    check_model();
    model_next();
    @(negedge clk);
  endtask

  initial begin
    bit en_r, mv;
    logic [31:0] thr, met;
    // fill then detect: threshold 1000, metrics 500/999/1000/1001 for windows 0..3
    add_v(1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) add_v(1, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_v(1, 1, 0, 0, 2, 0, 1, 0);
    add_v(1, 0, 0, 0, 2, 0, 1, 0);
    add_v(1, 0, 1, 500, 2, 0, 0, 0);
    add_v(1, 0, 1, 999, 2, 0, 0, 0);
    add_v(1, 0, 1, 1000, 2, 0, 0, 0);
    add_v(1, 0, 1, 1001, 2, 0, 0, 0);
    add_v(1, 0, 0, 0, 3, 0, 0, 1);

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_model();
    chk("reset_state", state, 0);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; s_valid = vecs[i].sv; metric_valid = vecs[i].mv;
      metric = vecs[i].met; threshold = 1000;
      #1;
      chk($sformatf("tbl%0d_state", i), state, vecs[i].st);
      chk($sformatf("tbl%0d_clr", i), buf_clr, vecs[i].clr);
      chk($sformatf("tbl%0d_cs", i), corr_start, vecs[i].cs);
      chk($sformatf("tbl%0d_found", i), uw_found, vecs[i].fnd);
      step(vecs[i].en, vecs[i].sv, vecs[i].mv, vecs[i].met, 1000);
    end
    chk("detect_pos", uw_pos, 18);
    chk("detect_metric", uw_metric, 1001);

    // hold-off: 4 ignored metrics, the 5th detects again
    repeat (5) step(1, 1, 0, 0, 1000);
    step(1, 0, 0, 0, 1000);
    repeat (4) begin
      step(1, 0, 1, 5000, 1000);
      chk("holdoff_no_found", uw_found, 0);
    end
    chk("holdoff_exit_state", state, 2);
    step(1, 0, 1, 5000, 1000);
    chk("holdoff_found", uw_found, 1);
    chk("holdoff_pos", uw_pos, 23);
    chk("holdoff_state", state, 3);

    // metrics during hold: tracked only with peak tracking
    repeat (2) step(1, 1, 0, 0, 1000);
    step(1, 0, 0, 0, 1000);
    step(1, 0, 1, 6000, 1000);
    chk("hold_no_found", uw_found, 0);
`ifdef UW_PEAK_TRACK_EN
    chk("peak_update_first", uw_update, 1);
`endif
    step(1, 0, 1, 5500, 1000);
`ifdef UW_PEAK_TRACK_EN
    chk("peak_update_second", uw_update, 0);
    chk("peak_metric", uw_metric, 6000);
    chk("peak_pos", uw_pos, 24);
`else
    chk("hold_metric_kept", uw_metric, 5000);
    chk("hold_pos_kept", uw_pos, 23);
`endif

    // disable with 3 requests in flight, drain, restart
    repeat (3) step(1, 1, 0, 0, 1000);
    step(0, 0, 0, 0, 1000);
    chk("disable_idle", state, 0);
    repeat (2) step(1, 0, 0, 0, 1000);
    chk("drain_wait_clr", buf_clr, 0);
    repeat (3) begin
      step(1, 0, 1, 9999, 1000);
      chk("drain_idle", state, 0);
    end
    chk("drain_no_found", uw_found, 0);
    chk("restart_clr", buf_clr, 1);
    step(1, 0, 0, 0, 1000);
    repeat (16) step(1, 1, 0, 0, 1000);
    step(1, 0, 0, 0, 1000);
    step(1, 0, 1, 7000, 1000);
    chk("restart_found", uw_found, 1);
    chk("restart_pos", uw_pos, 15);
    chk("restart_metric", uw_metric, 7000);

    // spurious metric in IDLE
    step(0, 0, 0, 0, 1000);
    chk("spur_idle", state, 0);
    step(0, 0, 1, 0, 1000);
    chk("spur_set", err_spur, 1);
    repeat (3) step(0, 0, 0, 0, 1000);
    chk("spur_sticky", err_spur, 1);

    // async reset in the middle of SEARCH
    step(1, 0, 0, 0, 1000);
    repeat (16) step(1, 1, 0, 0, 1000);
    step(1, 1, 0, 0, 1000);
    chk("pre_rst_cs", corr_start, 1);
    #2;
    rst = 0; enable = 1; s_valid = 1;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_buf_en", buf_en, 0);
    chk("rst_buf_clr", buf_clr, 0);
    chk("rst_corr_start", corr_start, 0);
    chk("rst_uw_found", uw_found, 0);
    chk("rst_uw_pos", uw_pos, 0);
    chk("rst_uw_metric", uw_metric, 0);
    chk("rst_state", state, 0);
    chk("rst_err_spur", err_spur, 0);
`ifdef UW_PEAK_TRACK_EN
    chk("rst_uw_update", uw_update, 0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1;

    // randomized traffic against the model
    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en_r = !en_r;
      thr = $urandom_range(900, 1100);
      mv  = m_out > 0 && (m_out >= 12 || $urandom_range(0, 1) == 1);
      met = ($urandom_range(0, 3) == 0) ? thr : 32'($urandom_range(0, 2000));
      step(en_r, $urandom_range(0, 1) == 1, mv, met, thr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
